// File: rtl/pc_fetch.sv
// Instruction-fetch sequencer: PC register, one-outstanding memory read, decode handoff.
// Optional memory-timeout detection is compiled in with `define FETCH_TIMEOUT_EN.
module pc_fetch #(
  parameter int              AW       = 16,
  parameter int              DW       = 32,
  parameter logic [AW-1:0]   RESET_PC = '0,
  parameter int              TIMEOUT  = 15
) (
  input  logic          clk,
  input  logic          rst,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic [DW-1:0] inst_data,
  output logic [AW-1:0] inst_pc,
  output logic          fetch_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DRAIN = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] inst_data_q, inst_data_d;
  logic [AW-1:0] inst_pc_q, inst_pc_d;
  logic          load_addr;

  assign mem_req    = (state_q == S_REQ) || (state_q == S_DRAIN);
  assign mem_addr   = mem_addr_q;
  assign inst_valid = (state_q == S_HOLD);
  assign inst_data  = inst_data_q;
  assign inst_pc    = inst_pc_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_data_d = inst_data_q;
    inst_pc_d   = inst_pc_q;
    load_addr   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (redirect) pc_d = redirect_pc;
        state_d   = S_REQ;
        load_addr = 1'b1;
      end
      S_REQ: begin
        if (redirect) begin
          pc_d = redirect_pc;
          // An ack coinciding with redirect closes the handshake, so the
          // new address can go out immediately; otherwise drain the old one.
          if (mem_ack) load_addr = 1'b1;
          else         state_d   = S_DRAIN;
        end else if (mem_ack) begin
          inst_data_d = mem_rdata;
          inst_pc_d   = pc_q;
          pc_d        = pc_q + AW'(4);
          state_d     = S_HOLD;
        end
      end
      S_DRAIN: begin
        if (redirect) pc_d = redirect_pc;
        if (mem_ack) begin
          state_d   = S_REQ;
          load_addr = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_d      = redirect_pc;
          state_d   = S_REQ;
          load_addr = 1'b1;
        end else if (inst_ready) begin
          state_d   = S_REQ;
          load_addr = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // mem_addr only moves when a new request begins, never mid-handshake.
    mem_addr_d = load_addr ? pc_d : mem_addr_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      mem_addr_q  <= '0;
      inst_data_q <= '0;
      inst_pc_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      mem_addr_q  <= mem_addr_d;
      inst_data_q <= inst_data_d;
      inst_pc_q   <= inst_pc_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int            CW     = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT);

  logic [CW-1:0] to_cnt_q, to_cnt_d;
  logic          fetch_err_q, fetch_err_d;

  assign fetch_err = fetch_err_q;

  always_comb begin
    to_cnt_d    = to_cnt_q;
    fetch_err_d = fetch_err_q;
    if (!mem_req || mem_ack || redirect)
      to_cnt_d = '0;
    else if (to_cnt_q != TO_LIM)
      to_cnt_d = to_cnt_q + CW'(1);
    if (to_cnt_d == TO_LIM && to_cnt_d != '0) fetch_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      to_cnt_q    <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      to_cnt_q    <= to_cnt_d;
      fetch_err_q <= fetch_err_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign fetch_err      = 1'b0;
`endif

endmodule
